div_issue_ctrl: RTL

- Request front-end and result collector wrapped around the 5-stage pipelined divider/modulo.
- The divider does not pipeline its dividend or mode, so operands must stay stable for the whole computation. This block accepts one request at a time over valid/ready and holds the operands on the divider.
- It captures the divider result on valid_out, corrects a negative non-restoring remainder, and presents the result over a valid/ready output handshake.
- It also flags divide-by-zero and a missing-valid_out timeout.

---
 rtl/div_pkg.sv | 9 +
 rtl/rem_fix.sv | 13 +
 rtl/div_issue_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared state encoding and constants for the divider issue/collect controller.
package div_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, DONE} state_t;

  localparam int          ERR_DIV0    = 0;
  localparam int          ERR_TMO     = 1;
  localparam int          DIV_LATENCY = 5;
  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/rem_fix.sv
// Non-restoring remainder correction: conditionally adds the divisor back (mod 2^16).
module rem_fix
  import div_pkg::*;
(
  input  logic        en,
  input  logic [15:0] rem,
  input  logic [15:0] divisor,
  output logic [15:0] fixed
);

  assign fixed = en ? (rem + divisor) : rem;

endmodule

// File: rtl/div_issue_ctrl.sv
// Single-request front-end for the pipelined divider: holds operands, collects
// and corrects the result, and flags divide-by-zero and missing-result timeout.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int LATENCY = DIV_LATENCY,
  parameter int TIMEOUT = 8,
  parameter int REM_FIX = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [31:0] req_dividend,
  input  logic [15:0] req_divisor,
  output logic        div_valid_in,
  output logic        div_mode,
  output logic [31:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic [31:0] div_result,
  input  logic        div_valid_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_err,
  output logic        busy
);

  // Counter is sized for the larger of the two so a mis-set TIMEOUT still fits.
  localparam int             CW        = $clog2((TIMEOUT > LATENCY ? TIMEOUT : LATENCY) + 1);
  localparam logic [CW-1:0]  TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [1:0]     DIV0_MASK = 2'(1 << ERR_DIV0);
  localparam logic [1:0]     TMO_MASK  = 2'(1 << ERR_TMO);

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [15:0]   captured;
  logic [15:0]   fixed_rem;
  logic          fix_needed;
  logic          unused_hi;

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign div_valid_in = (state == ISSUE);
  assign out_valid    = (state == DONE);
  assign fix_needed   = (REM_FIX != 0) && div_mode && div_result[15];
  assign unused_hi    = ^div_result[31:17];

  rem_fix u_rem_fix (
    .en      (state == FIX),
    .rem     (captured),
    .divisor (div_divisor),
    .fixed   (fixed_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      captured     <= '0;
      div_mode     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_result   <= '0;
      out_err      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            div_mode     <= req_mode;
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            if (req_divisor == 16'h0) begin
              out_result <= DIV0_RESULT;
              out_err    <= DIV0_MASK;
              state      <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (div_valid_out) begin
            captured <= div_result[15:0];
            out_err  <= '0;
            if (fix_needed) begin
              state <= FIX;
            end else begin
              out_result <= div_mode ? {16'h0, div_result[15:0]} : {15'h0, div_result[16:0]};
              state      <= DONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            out_result <= '0;
            out_err    <= TMO_MASK;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FIX: begin
          out_result <= {16'h0, fixed_rem};
          out_err    <= '0;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
